// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory port controller: size codes, FSM states, I/O region tag.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_WORD2 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_e;

  // ram_a[17:16] value marking read-sensitive I/O space; such addresses must be touched once.
  localparam logic [1:0] IO_REGION = 2'b11;

  // Number of bytes moved for a size code; both word encodings move four bytes.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_ctrl_arb.sv
// mem_rr_arbiter: one-hot grant from a request vector, round-robin from ptr or fixed lowest-index.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is taken (MEMCTRL_ROUND_ROBIN_EN enables ptr).
module mem_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt
);

  int rank [NUM_PORTS];

`ifdef MEMCTRL_ROUND_ROBIN_EN
  // Rank each port by its distance from the search start; rank 0 is most favoured.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rank[i] = (i + NUM_PORTS - int'(ptr)) % NUM_PORTS;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Fixed priority: the port index is its rank, so port 0 always wins.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rank[i] = i;
    end
  end
`endif

  // Grant the requesting port that no other requesting port outranks.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt[i] = req[i];
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (req[j] && (rank[j] < rank[i])) gnt[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: arbitrates NUM_PORTS byte/half/word requests onto a byte-wide synchronous RAM.
// Latency: write done 1+n cycles after grant, read done 2+n (word 5/6); one IDLE cycle between grants.
// Backpressure: rdy=0 freezes all state and masks ram_wr; MEMCTRL_ROUND_ROBIN_EN selects round-robin.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS-1:0]         req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*2-1:0]       req_size,
  input  logic [NUM_PORTS*32-1:0]      req_wdata,
  output logic [NUM_PORTS-1:0]         resp_done,
  output logic [31:0]                  resp_rdata,
  output logic [NUM_PORTS-1:0]         busy,
  input  logic [7:0]                   ram_din,
  output logic [7:0]                   ram_dout,
  output logic                         ram_wr,
  output logic [31:0]                  ram_a
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            n_q, n_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            k_q, k_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;

  logic [NUM_PORTS-1:0]  gnt;
  logic [PTR_W-1:0]      arb_ptr;
  logic                  grant_vld;
  logic                  last_cycle;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [1:0]            sel_size;
  logic [31:0]           sel_wdata;
  logic [2:0]            k_nxt;
  logic [2:0]            rd_idx;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  mem_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req (req_valid),
    .ptr (arb_ptr),
    .gnt (gnt)
  );

`ifdef MEMCTRL_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next search starts one past the port just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt[i]) ptr_d = PTR_W'((i + 1) % NUM_PORTS);
      end
    end
  end

  // Arbitration pointer register, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst)      ptr_q <= '0;
    else if (rdy) ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = '0;
`endif

  assign grant_vld = (state_q == IDLE) && (|gnt);
  assign k_nxt     = k_q + 3'd1;
  assign rd_idx    = k_q - 3'd1;
  assign addr_nxt  = addr_q + ADDR_WIDTH'(k_nxt);
  // Writes end on the last byte cycle; reads need one more cycle for the final RAM byte.
  assign last_cycle = we_q ? (k_nxt == n_q) : (k_q == n_q);

  // Pick the granted port's request fields out of the packed input buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_size  = 2'b00;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size  = req_size[i*2 +: 2];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  // FSM state register; reset beats rdy, rdy=0 holds the current position.
  always_ff @(posedge clk) begin
    if (rst)      state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  // FSM next state: grant only from IDLE, so DONE never re-grants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = XFER;
      XFER:    if (last_cycle) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch at grant, step one byte per cycle, park the RAM bus at zero after.
  always_comb begin
    port_d     = port_q;
    we_d       = we_q;
    addr_d     = addr_q;
    n_d        = n_q;
    wdata_d    = wdata_q;
    k_d        = k_q;
    rdata_d    = rdata_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          port_d     = gnt;
          we_d       = sel_we;
          addr_d     = sel_addr;
          n_d        = byte_count(sel_size);
          wdata_d    = sel_wdata;
          k_d        = 3'd0;
          rdata_d    = '0;
          ram_a_d    = 32'(sel_addr);
          ram_dout_d = sel_we ? sel_wdata[7:0] : 8'h00;
          ram_wr_d   = sel_we;
        end
      end
      XFER: begin
        k_d = k_nxt;
        // RAM returns byte k one cycle after its address, i.e. while k_q = k+1.
        if (!we_q && (k_q != 3'd0)) begin
          rdata_d = rdata_q | ({24'h0, ram_din} << {rd_idx, 3'b000});
        end
        if (k_nxt < n_q) begin
          ram_a_d    = 32'(addr_nxt);
          ram_dout_d = we_q ? 8'(wdata_q >> {k_nxt, 3'b000}) : 8'h00;
          ram_wr_d   = we_q;
        end else begin
          // Move off the last address so an I/O location is never presented twice.
          ram_a_d    = '0;
          ram_dout_d = 8'h00;
          ram_wr_d   = 1'b0;
        end
      end
      default: begin
        k_d = 3'd0;
      end
    endcase
  end

  // Datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      n_q        <= 3'd0;
      wdata_q    <= '0;
      k_q        <= 3'd0;
      rdata_q    <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'h00;
      ram_wr_q   <= 1'b0;
    end else if (rdy) begin
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      wdata_q    <= wdata_d;
      k_q        <= k_d;
      rdata_q    <= rdata_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  // FSM outputs: completion pulse from DONE, write strobe masked while paused.
  always_comb begin
    resp_done = (state_q == DONE) ? port_q : '0;
    ram_wr    = ram_wr_q & rdy;
  end

  assign busy       = req_valid & ~resp_done;
  assign resp_rdata = rdata_q;
  assign ram_a      = ram_a_q;
  assign ram_dout   = ram_dout_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: main instance (2 ports, 18-bit) plus a 1-port 17-bit instance.
// Latency: expected cycle counts are hand-computed from the grant cycle.
// Backpressure: rdy is stalled in one directed write.
module tb_mem_port_ctrl;
  import mem_ctrl_pkg::*;

  localparam int NP = 2;
  localparam int AW = 18;
  localparam logic [31:0] IO_ADDR = {14'b0, IO_REGION, 16'h0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, rdy;
  logic [NP-1:0]        req_valid, req_we;
  logic [NP*AW-1:0]     req_addr;
  logic [NP*2-1:0]      req_size;
  logic [NP*32-1:0]     req_wdata;
  logic [NP-1:0]        resp_done, busy;
  logic [31:0]          resp_rdata;
  logic [7:0]           ram_din, ram_dout;
  logic                 ram_wr;
  logic [31:0]          ram_a;

  logic                 s_rst, s_rdy, s_req_valid, s_req_we;
  logic [16:0]          s_req_addr;
  logic [1:0]           s_req_size;
  logic [31:0]          s_req_wdata;
  logic                 s_resp_done, s_busy;
  logic [31:0]          s_resp_rdata;
  logic [7:0]           s_ram_din, s_ram_dout;
  logic                 s_ram_wr;
  logic [31:0]          s_ram_a;

  int errors = 0;
  int checks = 0;

  mem_port_ctrl #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .resp_done(resp_done), .resp_rdata(resp_rdata), .busy(busy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_a(ram_a)
  );

  mem_port_ctrl #(.NUM_PORTS(1), .ADDR_WIDTH(17)) dut17 (
    .clk(clk), .rst(s_rst), .rdy(s_rdy),
    .req_valid(s_req_valid), .req_we(s_req_we), .req_addr(s_req_addr),
    .req_size(s_req_size), .req_wdata(s_req_wdata),
    .resp_done(s_resp_done), .resp_rdata(s_resp_rdata), .busy(s_busy),
    .ram_din(s_ram_din), .ram_dout(s_ram_dout), .ram_wr(s_ram_wr), .ram_a(s_ram_a)
  );

  // Synchronous byte RAM with one-cycle read latency, plus an I/O address touch counter.
  logic [7:0] mem [0:(1<<AW)-1];
  int io_hits = 0;
  always @(posedge clk) begin
    if (ram_a == IO_ADDR) io_hits <= io_hits + 1;
    ram_din <= mem[ram_a[AW-1:0]];
    if (ram_wr) mem[ram_a[AW-1:0]] <= ram_dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from port p in the current (IDLE) cycle and report cycles-to-done.
  task automatic run_txn(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [1:0] size, input logic [31:0] wd,
                         input int stall_at, input int stall_len,
                         output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = addr;
    req_size[p*2 +: 2]    = size;
    req_wdata[p*32 +: 32] = wd;
    for (int c = 1; c <= 30 && lat < 0; c++) begin
      tick();
      if (c == 1) check_eq("busy_in_xfer", busy[p], 1'b1);
      if (resp_done[p]) begin
        lat = c;
        rd  = resp_rdata;
        req_valid[p] = 1'b0;
      end else if (c >= stall_at && c < stall_at + stall_len) begin
        rdy = 1'b0;
        #1;
        check_eq("wr_masked_stall", ram_wr, 1'b0);
      end else begin
        rdy = 1'b1;
      end
    end
    rdy = 1'b1;
    req_valid[p] = 1'b0;
    tick();
  endtask

  int lat;
  logic [31:0] rd;
  logic [NP-1:0] seen [4];
  logic [NP-1:0] exp_seq [4];
  int ndone;
  int io_base;
  logic saw;

  initial begin
    rst = 1'b1; rdy = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_size = '0; req_wdata = '0;
    s_rst = 1'b1; s_rdy = 1'b1; s_req_valid = 1'b0; s_req_we = 1'b0;
    s_req_addr = '0; s_req_size = 2'b00; s_req_wdata = '0; s_ram_din = 8'h00;
    mem[18'h00100] <= 8'h11; mem[18'h00101] <= 8'h22;
    mem[18'h00102] <= 8'h33; mem[18'h00103] <= 8'h44;
    mem[18'h02000] <= 8'h9A; mem[18'h02001] <= 8'h78;
    mem[18'h30000] <= 8'hA5; mem[18'h30001] <= 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; s_rst = 1'b0;

    check_eq("rst_ram_a", ram_a, 32'h0);
    check_eq("rst_ram_wr", ram_wr, 1'b0);
    check_eq("rst_ram_dout", ram_dout, 8'h00);
    check_eq("rst_resp_done", resp_done, 2'b00);
    check_eq("rst_resp_rdata", resp_rdata, 32'h0);
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Word read at 0x100: bytes assemble little-endian, done at grant+6.
    run_txn(0, 1'b0, 18'h00100, SIZE_WORD, 32'h0, 0, 0, lat, rd);
    check_eq("word_rd_lat", lat, 6);
    check_eq("word_rd_data", rd, 32'h44332211);

    // Half read on port 1: upper half zero, done at grant+4.
    run_txn(1, 1'b0, 18'h02000, SIZE_HALF, 32'h0, 0, 0, lat, rd);
    check_eq("half_rd_lat", lat, 4);
    check_eq("half_rd_data", rd, 32'h0000789A);

    // Plain word write: done at grant+5.
    run_txn(0, 1'b1, 18'h00300, SIZE_WORD, 32'h0BADF00D, 0, 0, lat, rd);
    check_eq("word_wr_lat", lat, 5);
    check_eq("word_wr_mem", {mem[18'h00303], mem[18'h00302], mem[18'h00301], mem[18'h00300]}, 32'h0BADF00D);

    // Word write with rdy low for 3 cycles on byte 2: done slips from 5 to 8.
    run_txn(0, 1'b1, 18'h00200, SIZE_WORD, 32'hA1B2C3D4, 3, 3, lat, rd);
    check_eq("stall_wr_lat", lat, 8);
    check_eq("stall_wr_mem", {mem[18'h00203], mem[18'h00202], mem[18'h00201], mem[18'h00200]}, 32'hA1B2C3D4);

    // Byte read in I/O space: one address cycle only, no sign extension of 0xA5.
    io_base = io_hits;
    run_txn(0, 1'b0, IO_ADDR[AW-1:0], SIZE_BYTE, 32'h0, 0, 0, lat, rd);
    check_eq("io_rd_lat", lat, 3);
    check_eq("io_rd_data", rd, 32'h000000A5);
    check_eq("io_single_addr", io_hits - io_base, 1);

    // Half write across the 17-bit wrap on the second instance.
    s_req_valid = 1'b1; s_req_we = 1'b1; s_req_addr = 17'h1FFFF;
    s_req_size = SIZE_HALF; s_req_wdata = 32'h0000BEEF;
    tick();
    check_eq("wrap_a0", s_ram_a, 32'h0001FFFF);
    check_eq("wrap_d0", s_ram_dout, 8'hEF);
    check_eq("wrap_wr0", s_ram_wr, 1'b1);
    tick();
    check_eq("wrap_a1", s_ram_a, 32'h00000000);
    check_eq("wrap_d1", s_ram_dout, 8'hBE);
    check_eq("wrap_wr1", s_ram_wr, 1'b1);
    check_eq("wrap_not_done", s_resp_done, 1'b0);
    tick();
    check_eq("wrap_done", s_resp_done, 1'b1);
    check_eq("wrap_wr_off", s_ram_wr, 1'b0);
    s_req_valid = 1'b0;
    tick();

    // Reset during the XFER of a read: aborted silently, then a fresh read works.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 18'h00100; req_size[1:0] = SIZE_WORD;
    tick();
    tick();
    check_eq("pre_rst_state", 32'(dut.state_q), 32'(XFER));
    rst = 1'b1;
    req_valid[0] = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (resp_done != '0 || ram_wr) saw = 1'b1;
      tick();
    end
    check_eq("post_rst_quiet", saw, 1'b0);
    run_txn(0, 1'b0, 18'h00100, SIZE_WORD, 32'h0, 0, 0, lat, rd);
    check_eq("post_rst_lat", lat, 6);
    check_eq("post_rst_data", rd, 32'h44332211);

    // Both ports requesting continuously from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
    req_we = 2'b11; req_size = {SIZE_BYTE, SIZE_BYTE};
    req_addr = {18'h00500, 18'h00400};
    req_wdata = {32'h000000BB, 32'h000000AA};
    req_valid = 2'b11;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 4; c++) begin
      tick();
      if (resp_done != '0) begin
        seen[ndone] = resp_done;
        ndone++;
      end
    end
    req_valid = 2'b00;
    check_eq("arb_count", ndone, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ndone) check_eq($sformatf("arb_grant%0d", i), seen[i], exp_seq[i]);
    end
    tick();
    tick();
    check_eq("arb_mem_p0", mem[18'h00400], 8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL take parameter NUM_PORTS, default 2: number of requesting ports, legal range 1..8.
REQ-002 SHALL take parameter ADDR_WIDTH, default 18: significant address bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port rdy, input, 1 bit: when low, the block pauses.
REQ-006 SHALL have port req_valid, input, NUM_PORTS bits: per-port request.
REQ-007 SHALL have port req_we, input, NUM_PORTS bits: 1=write, 0=read.
REQ-008 SHALL have port req_addr, input, NUM_PORTS*ADDR_WIDTH bits: byte address, packed, port i at slice i.
REQ-009 SHALL have port req_size, input, NUM_PORTS*2 bits: 00=byte, 01=half, 10=word, 11=word.
REQ-010 SHALL have port req_wdata, input, NUM_PORTS*32 bits: write data, little-endian.
REQ-011 SHALL have port resp_done, output, NUM_PORTS bits: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: read data, valid while any resp_done bit is high.
REQ-013 SHALL have port busy, output, NUM_PORTS bits: high when req_valid[i]=1 and resp_done[i]=0.
REQ-014 SHALL have port ram_din, input, 8 bits: memory read byte.
REQ-015 SHALL have ports ram_dout (8 bits), ram_wr (1 bit) and ram_a (32 bits), all outputs: memory write byte, write strobe, address.

Function
REQ-016 SHALL use states IDLE, XFER and DONE.
- IDLE to XFER on grant.
- XFER to DONE after the last byte.
- DONE to IDLE unconditionally.
REQ-017 SHALL arbitrate only in IDLE, and SHALL latch the granted port's we, addr, size and wdata at grant.
REQ-018 SHALL set byte count n to 1, 2 or 4 per req_size; byte k SHALL be at address (addr+k) mod 2^ADDR_WIDTH, on ram_a zero-extended to 32 bits.
REQ-019 SHALL register ram_a and ram_dout, and for grant in cycle G SHALL drive byte k's address during cycle G+1+k.
REQ-020 SHALL drive ram_wr=1 with byte k on ram_dout during cycle G+1+k for a write, and SHALL assert resp_done during cycle G+1+n.
REQ-021 SHALL sample ram_din at the edge ending cycle G+2+k for a read, and SHALL assert resp_done during cycle G+2+n.
- Byte k goes to resp_rdata[8k+7:8k].
- Unused upper bytes SHALL read as zero, with no sign extension.
REQ-022 SHALL keep ram_wr=0 outside write byte cycles.
REQ-023 SHALL issue exactly n addresses, with no speculative reads, so I/O addresses (ram_a[17:16]=11) are never read twice.
REQ-024 SHALL NOT grant any port in DONE, so the completing port may drop or change its request in that cycle without a re-grant.
REQ-025 SHALL complete a granted transaction and pulse resp_done even if req_valid drops mid-transfer.
REQ-026 SHALL freeze all state while rdy=0, SHALL force ram_wr to 0 combinationally, and SHALL resume the same cycle position when rdy returns.
REQ-027 SHALL sample ram_din only on edges with rdy=1.
REQ-028 SHALL, for a word read, assert resp_done 6 cycles after the grant cycle, and for a word write 5 cycles after it; back-to-back grants SHALL occur no sooner than 1 cycle after DONE.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, return to state IDLE and clear to zero: arbitration pointer, ram_a, ram_dout, ram_wr, resp_done, resp_rdata and the latched request.
REQ-030 SHALL abort a transaction hit by reset mid-operation, with no resp_done pulse and no further ram_wr.
REQ-031 SHALL give reset priority over rdy=0.

Configuration
REQ-032 SHALL use round-robin arbitration when MEMCTRL_ROUND_ROBIN_EN is defined: search starts at the port after the last granted port, and the pointer is 0 after reset.
REQ-033 SHALL use fixed priority when MEMCTRL_ROUND_ROBIN_EN is undefined: lowest index wins, with no pointer register.

Structure
REQ-034 SHALL take from shared package mem_ctrl_pkg:
- size encodings;
- state encoding;
- IO_REGION constant 2'b11;
- byte-count function.
REQ-035 SHALL contain one sub-module, mem_rr_arbiter (request vector plus pointer in, one-hot grant out), whose pointer logic is enabled by the macro.

Verification
REQ-036 SHALL verify a single-port word read at 0x00100 returning bytes 11,22,33,44: resp_rdata=0x44332211, with resp_done 6 cycles after grant.
REQ-037 SHALL verify a half write 0xBEEF to 0x1FFFF with ADDR_WIDTH=17: ram_a sequence 0x1FFFF then 0x00000, ram_dout EF then BE, resp_done 3 cycles after grant.
REQ-038 SHALL verify both ports requesting continuously with round-robin enabled: grants alternate 0,1,0,1; with the macro undefined, port 0 is always granted.
REQ-039 SHALL verify rdy held low 3 cycles during byte 2 of a word write: no ram_wr while low, and completion is delayed exactly 3 cycles.
REQ-040 SHALL verify rst asserted in XFER of a read: no resp_done, state IDLE, and a fresh request completes normally.
REQ-041 SHALL verify a byte read at 0x30000: exactly one ram_a=0x30000 cycle, and resp_rdata upper 24 bits zero.
